uart_req_assembler: RTL and testbench

Collects two consecutive bytes from the UART receiver (command, then address) into one request word. It presents the request to the downstream command handler over a valid/ack handshake. It sits directly downstream of the 8N1 receiver and consumes its one-cycle done strobe and data byte. It also enforces an inter-byte timeout and range-checks the address, so the handler only ever sees complete, legal requests.

---
 rtl/uart_req_assembler.sv | 124 ++++++++++++
 tb/tb_uart_req_assembler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_req_assembler.sv
// Pairs a command byte and an address byte from the UART receiver into one
// range-checked request, offered downstream over a level valid/ack handshake.
module uart_req_assembler #(
  parameter int unsigned TIMEOUT_CLKS = 694400,
  parameter logic [7:0]  MAX_CMD      = 8'h07,
  parameter logic [7:0]  MAX_ADDR     = 8'd31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  input  logic       req_ack,
  output logic       req_valid,
  output logic [7:0] req_cmd,
  output logic [7:0] req_addr,
  output logic       cmd_err,
  output logic       addr_err,
  output logic       timeout_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [1:0]  S_WAIT_CMD  = 2'd0;
  localparam logic [1:0]  S_WAIT_ADDR = 2'd1;
  localparam logic [1:0]  S_HOLD      = 2'd2;
  localparam logic [23:0] TIMER_TERM  = 24'(TIMEOUT_CLKS - 1);

  logic [1:0]  state_q, state_d;
  logic [23:0] timer_q, timer_d;
  logic [7:0]  req_cmd_q, req_cmd_d, req_addr_q, req_addr_d;
  logic        req_valid_q, req_valid_d;
  logic        cmd_err_q, cmd_err_d, addr_err_q, addr_err_d;
  logic        timeout_err_q, timeout_err_d, overrun_q, overrun_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    req_cmd_d     = req_cmd_q;
    req_addr_d    = req_addr_q;
    req_valid_d   = req_valid_q;
    cmd_err_d     = 1'b0;
    addr_err_d    = 1'b0;
    timeout_err_d = 1'b0;
    overrun_d     = 1'b0;
    case (state_q)
      S_WAIT_CMD: begin
        // 8'h00 is line idle fill and is dropped without complaint
        if (rx_done && rx_data != 8'h00) begin
          if (rx_data <= MAX_CMD) begin
            req_cmd_d = rx_data;
            timer_d   = '0;
            state_d   = S_WAIT_ADDR;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      S_WAIT_ADDR: begin
        // A byte on the terminal cycle takes priority over the timeout
        if (rx_done) begin
          if (rx_data <= MAX_ADDR) begin
            req_addr_d  = rx_data;
            req_valid_d = 1'b1;
            state_d     = S_HOLD;
          end else begin
            addr_err_d = 1'b1;
            state_d    = S_WAIT_CMD;
          end
        end else if (timer_q == TIMER_TERM) begin
          timeout_err_d = 1'b1;
          state_d       = S_WAIT_CMD;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 24'd1;
        end
      end
      S_HOLD: begin
        overrun_d = rx_done;
        if (req_ack) begin
          req_valid_d = 1'b0;
          state_d     = S_WAIT_CMD;
        end
      end
      default: state_d = S_WAIT_CMD;
    endcase
    busy_d = (state_d != S_WAIT_CMD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_WAIT_CMD;
      timer_q       <= '0;
      req_cmd_q     <= '0;
      req_addr_q    <= '0;
      req_valid_q   <= 1'b0;
      cmd_err_q     <= 1'b0;
      addr_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      req_cmd_q     <= req_cmd_d;
      req_addr_q    <= req_addr_d;
      req_valid_q   <= req_valid_d;
      cmd_err_q     <= cmd_err_d;
      addr_err_q    <= addr_err_d;
      timeout_err_q <= timeout_err_d;
      overrun_q     <= overrun_d;
      busy_q        <= busy_d;
    end
  end

  assign req_valid   = req_valid_q;
  assign req_cmd     = req_cmd_q;
  assign req_addr    = req_addr_q;
  assign cmd_err     = cmd_err_q;
  assign addr_err    = addr_err_q;
  assign timeout_err = timeout_err_q;
  assign overrun     = overrun_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_req_assembler.sv
// Directed scenarios plus randomized byte/ack/reset traffic against a
// cycle-count based reference model of the request assembler.
module tb_uart_req_assembler;

  localparam int unsigned TO       = 10;
  localparam logic [7:0]  MAX_CMD  = 8'h07;
  localparam logic [7:0]  MAX_ADDR = 8'd31;

  logic       clk = 1'b0;
  logic       rst_n, rx_done, req_ack;
  logic [7:0] rx_data;
  logic       req_valid, cmd_err, addr_err, timeout_err, overrun, busy;
  logic [7:0] req_cmd, req_addr;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  bit chk_on   = 1'b0;

  uart_req_assembler #(.TIMEOUT_CLKS(TO), .MAX_CMD(MAX_CMD), .MAX_ADDR(MAX_ADDR)) dut (
    .clk(clk), .rst_n(rst_n), .rx_done(rx_done), .rx_data(rx_data), .req_ack(req_ack),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_addr(req_addr), .cmd_err(cmd_err),
    .addr_err(addr_err), .timeout_err(timeout_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: phase 0 = waiting for command, 1 = have command, 2 = request pending.
  // Timeout is judged from absolute edge numbers rather than a running timer.
  int         m_phase = 0;
  int         m_edge = 0, m_acc_edge = 0;
  logic [7:0] m_cmd = 0, m_addr = 0;
  logic       m_valid = 0, m_cerr = 0, m_aerr = 0, m_terr = 0, m_ovr = 0;

  // Outputs are compared at the falling edge; the model then predicts the next rising edge
  // from the inputs, which are held stable between 1ns after one rising edge and the next.
  always @(negedge clk) begin
    if (chk_on)
      check("outputs",
            {10'd0, req_valid, req_cmd, req_addr, cmd_err, addr_err, timeout_err, overrun, busy},
            {10'd0, m_valid, m_cmd, m_addr, m_cerr, m_aerr, m_terr, m_ovr, (m_phase != 0)});
    m_edge++;
    m_cerr = 0; m_aerr = 0; m_terr = 0; m_ovr = 0;
    if (!rst_n) begin
      m_phase = 0; m_cmd = 0; m_addr = 0; m_valid = 0;
    end else if (m_phase == 0) begin
      if (rx_done && rx_data != 0) begin
        if (rx_data <= MAX_CMD) begin m_cmd = rx_data; m_phase = 1; m_acc_edge = m_edge; end
        else m_cerr = 1;
      end
    end else if (m_phase == 1) begin
      if (rx_done) begin
        if (rx_data <= MAX_ADDR) begin m_addr = rx_data; m_valid = 1; m_phase = 2; end
        else begin m_aerr = 1; m_phase = 0; end
      end else if (m_edge - m_acc_edge == int'(TO)) begin
        m_terr = 1; m_phase = 0;
      end
    end else begin
      m_ovr = rx_done;
      if (req_ack) begin m_valid = 0; m_phase = 0; end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic byte_in(input logic [7:0] b);
    rx_done = 1'b1; rx_data = b;
    tick();
    rx_done = 1'b0; rx_data = 8'($urandom);
  endtask

  task automatic ack();
    req_ack = 1'b1;
    tick();
    req_ack = 1'b0;
  endtask

  initial begin
    int k;
    int rate;
    rst_n = 1'b0; rx_done = 1'b0; rx_data = 8'h00; req_ack = 1'b0;
    tick(); tick();
    chk_on = 1'b1;
    rst_n = 1'b1;
    check("reset_valid", req_valid, 1'b0);
    check("reset_cmd", req_cmd, 8'h00);
    check("reset_busy", busy, 1'b0);

    byte_in(8'h03);
    check("cmd_busy", busy, 1'b1);
    byte_in(8'h1A);
    check("req1_valid", req_valid, 1'b1);
    check("req1_fields", {req_cmd, req_addr}, 16'h031A);
    ack();
    check("ack_valid", req_valid, 1'b0);
    check("ack_busy", busy, 1'b0);

    byte_in(8'h00);
    check("idle_no_err", {cmd_err, busy}, 2'b00);
    byte_in(8'h09);
    check("cmd_err_pulse", cmd_err, 1'b1);
    tick();
    check("cmd_err_one_cycle", cmd_err, 1'b0);
    byte_in(8'h02); byte_in(8'h05);
    check("req2_fields", {req_valid, req_cmd, req_addr}, 17'h10205);
    ack();

    byte_in(8'h01); byte_in(8'h20);
    check("addr_err_pulse", {addr_err, req_valid, busy}, 3'b100);
    byte_in(8'h01); byte_in(8'h1F);
    check("req3_fields", {req_valid, req_cmd, req_addr}, 17'h1011F);
    ack();

    byte_in(8'h04);
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      tick();
      if (timeout_err) k = i;
    end
    check("timeout_latency", k, 10);
    tick();
    byte_in(8'h04);
    repeat (TO - 1) tick();
    byte_in(8'h11);
    check("terminal_byte_wins", {req_valid, timeout_err, req_addr}, 10'h211);
    ack();

    byte_in(8'h01); byte_in(8'h02);
    byte_in(8'h05);
    check("overrun_pulse", {overrun, req_valid, req_cmd, req_addr}, 18'h30102);
    rx_done = 1'b1; rx_data = 8'h05; req_ack = 1'b1;
    tick();
    rx_done = 1'b0; req_ack = 1'b0;
    check("overrun_with_ack", {overrun, req_valid}, 2'b10);
    tick();
    check("dropped_not_cmd", {overrun, busy}, 2'b00);

    byte_in(8'h03);
    rst_n = 1'b0; rx_done = 1'b1; rx_data = 8'h10;
    tick();
    rst_n = 1'b1; rx_done = 1'b0;
    check("reset_mid_frame", {req_valid, cmd_err, busy, req_cmd}, 11'h000);
    byte_in(8'h10);
    check("back_in_wait_cmd", {cmd_err, req_valid, busy}, 3'b100);

    for (int blk = 0; blk < 40; blk++) begin
      case ($urandom_range(2))
        0:       rate = 2;
        1:       rate = 6;
        default: rate = 16;
      endcase
      for (int i = 0; i < 100; i++) begin
        rx_done = ($urandom_range(rate - 1) == 0);
        rx_data = ($urandom_range(3) == 0) ? 8'($urandom) : 8'($urandom_range(40));
        req_ack = ($urandom_range(3) == 0);
        rst_n   = ($urandom_range(299) != 0);
        tick();
      end
    end
    rst_n = 1'b1; rx_done = 1'b0; req_ack = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
